// File: rtl/rs_pkg.sv
// Shared definitions for the reservation station: dispatched-bundle layout,
// ctrl bit positions and the per-entry storage record.
package rs_pkg;

    localparam int DECOMP_W    = 117;
    localparam int XLEN        = 32;
    localparam int REG_W       = 5;
    localparam int CTRL_W      = 14;

    // Field offsets inside the dispatched bundle.
    localparam int MEMDATA_LSB = 85;
    localparam int CTRL_LSB    = 71;
    localparam int RS2_LSB     = 39;
    localparam int S2V_BIT     = 38;
    localparam int RS1_LSB     = 6;
    localparam int S1V_BIT     = 5;

    // Bit positions inside ctrl.
    localparam int CTRL_FP       = 13;
    localparam int CTRL_MEMWRITE = 6;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   memdata;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  tag1;
        logic [REG_W-1:0]  tag2;
        logic              v1;
        logic              v2;
    } rs_entry_t;

    // Build a fresh entry from the dispatched bundle and its wakeup tags.
    function automatic rs_entry_t unpack_bundle(
        input logic [DECOMP_W-1:0] inst,
        input logic [REG_W-1:0]    rs1,
        input logic [REG_W-1:0]    rs2
    );
        rs_entry_t e;
        e.memdata = inst[MEMDATA_LSB +: XLEN];
        e.ctrl    = inst[CTRL_LSB +: CTRL_W];
        e.op2     = inst[RS2_LSB +: XLEN];
        e.v2      = inst[S2V_BIT];
        e.op1     = inst[RS1_LSB +: XLEN];
        e.v1      = inst[S1V_BIT];
        e.rd      = inst[REG_W-1:0];
        e.tag1    = rs1;
        e.tag2    = rs2;
        return e;
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: registers the value chosen by the top
// (hold, shifted neighbour or new dispatch) after applying forwarding-bus
// wakeup to it, so capture and compaction happen at the same edge.
module rs_entry
    import rs_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  rs_entry_t        d,
    input  logic             fwd_valid,
    input  logic [REG_W-1:0] fwd_addr,
    input  logic [XLEN-1:0]  fwd_data,
    output rs_entry_t        q
);

    rs_entry_t woken;

    // Wakeup compare and capture; x0 is never a producer.
    always_comb begin
        woken = d;
        if (fwd_valid && (fwd_addr != '0)) begin
            if (!d.v1 && (d.tag1 == fwd_addr)) begin
                woken.op1 = fwd_data;
                woken.v1  = 1'b1;
            end
            if (!d.v2 && (d.tag2 == fwd_addr)) begin
                woken.v2 = 1'b1;
                // Stores keep their immediate in op2; the register value is store data.
                if (d.ctrl[CTRL_MEMWRITE]) begin
                    woken.memdata = fwd_data;
                end else begin
                    woken.op2 = fwd_data;
                end
            end
        end
    end

    // Slot register; reset and flush wipe the whole record including v bits.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else begin
            q <= woken;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// In-order-aged reservation station. Entries form a compacting queue with
// index 0 oldest; the oldest entry with both operands valid is offered to
// the execution unit.
// Optional build macro: RS_PERF_CNT_EN enables the dispatch-stall counter.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid
// and ready are both high. disp_ready depends only on the occupancy count.
// issue_valid and the issue_* payload come from registered state only, so
// they do not depend on issue_ready and hold steady until accepted or
// flushed.
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DECOMP_W = rs_pkg::DECOMP_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [DECOMP_W-1:0]        disp_inst,
    input  logic [4:0]                 disp_rs1,
    input  logic [4:0]                 disp_rs2,
    input  logic                       fwd_valid,
    input  logic [4:0]                 fwd_addr,
    input  logic [31:0]                fwd_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_op1,
    output logic [31:0]                issue_op2,
    output logic [31:0]                issue_memdata,
    output logic [13:0]                issue_ctrl,
    output logic [4:0]                 issue_rd,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                perf_stall_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    rs_entry_t        q   [DEPTH];
    rs_entry_t        d   [DEPTH];
    rs_entry_t        up  [DEPTH];
    rs_entry_t        new_ent;
    logic [DEPTH-1:0] rdy;
    logic             found;
    logic [IW-1:0]    sel;
    logic             fire;
    logic             disp_fire;
    logic [CW-1:0]    wr_idx;
    logic [CW-1:0]    count_next;

    assign disp_ready = (count != CW'(DEPTH));
    // A dispatch in a flush cycle is dropped.
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign fire       = issue_valid && issue_ready;
    assign new_ent    = unpack_bundle(disp_inst, disp_rs1, disp_rs2);

    // Ready vector over occupied slots only; stale slots above count are ignored.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = (CW'(i) < count) && q[i].v1 && q[i].v2;
        end
    end

    // Oldest-ready select: scan from the top so the lowest index wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    // Issue payload is zeroed when nothing is ready so idle outputs stay clean.
    always_comb begin
        issue_valid   = found;
        issue_op1     = '0;
        issue_op2     = '0;
        issue_memdata = '0;
        issue_ctrl    = '0;
        issue_rd      = '0;
        if (found) begin
            issue_op1     = q[sel].op1;
            issue_op2     = q[sel].op2;
            issue_memdata = q[sel].memdata;
            issue_ctrl    = q[sel].ctrl;
            issue_rd      = q[sel].rd;
        end
    end

    // Neighbour feed for compaction; the top slot has no younger neighbour.
    for (genvar g = 0; g < DEPTH; g++) begin : g_up
        if (g < DEPTH - 1) begin : g_mid
            assign up[g] = q[g+1];
        end else begin : g_top
            assign up[g] = q[g];
        end
    end

    // Compaction and dispatch placement: slots at or above the issued one
    // take their younger neighbour; the new entry lands after the shift.
    always_comb begin
        wr_idx = fire ? (count - CW'(1)) : count;
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = (fire && (IW'(i) >= sel)) ? up[i] : q[i];
            if (disp_fire && (CW'(i) == wr_idx)) begin
                d[i] = new_ent;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .d         (d[g]),
            .fwd_valid (fwd_valid),
            .fwd_addr  (fwd_addr),
            .fwd_data  (fwd_data),
            .q         (q[g])
        );
    end

    // Occupancy next value: minus one on issue, plus one on dispatch.
    always_comb begin
        count_next = count;
        if (fire) begin
            count_next = count_next - CW'(1);
        end
        if (disp_fire) begin
            count_next = count_next + CW'(1);
        end
    end

    // Occupancy register; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef RS_PERF_CNT_EN
    // Saturating count of cycles where dispatch was blocked by a full queue;
    // survives flush so it measures the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (disp_valid && !disp_ready && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
